// File: rtl/uart_pkg.sv
// Shared types and constants for the UART framing stage.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8 register file, synchronous write, asynchronous read.
module frame_buf #(
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_data,
    input  logic [IW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_data
);

    logic [7:0] mem_q [DEPTH];

    // Contents deliberately survive reset; only indices are cleared upstream.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_idx];

endmodule

// File: rtl/uart_frame_parser.sv
// Sync-hunting, length-prefixed frame parser with additive checksum; releases
// the buffered payload on a valid/ready stream only after the checksum verifies.
//   state      | meaning
//   ST_HUNT    | waiting for SYNC, other bytes ignored
//   ST_LEN     | next byte is the payload length
//   ST_PAYLOAD | storing payload bytes, accumulating sum
//   ST_CHECK   | next byte is the checksum
//   ST_DRAIN   | presenting buffered payload downstream
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 4340
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          overrun_q, overrun_d;

    logic          buf_we;
    logic [7:0]    rd_data;
    logic          timed;
    logic          drain_last;

    frame_buf #(.DEPTH(MAX_LEN)) u_buf (
        .clk       (i_Clock),
        .i_we      (buf_we),
        .i_wr_idx  (wr_idx_q),
        .i_wr_data (i_RX_Byte),
        .i_rd_idx  (rd_idx_q),
        .o_rd_data (rd_data)
    );

    assign drain_last = (LW'(rd_idx_q) == len_q - LW'(1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        cnt_d       = '0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = 1'b0;
        buf_we      = 1'b0;
        timed       = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

        if (timed && !i_RX_DV) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            ST_HUNT: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_RX_DV) begin
                    if ((i_RX_Byte == 8'h00) || (i_RX_Byte > MAX_LEN_B)) begin
                        state_d     = ST_HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d    = i_RX_Byte[LW-1:0];
                        sum_d    = i_RX_Byte;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_RX_DV) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + i_RX_Byte;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (LW'(wr_idx_q) == len_q - LW'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (i_RX_DV) begin
                    if (8'(sum_q + i_RX_Byte) == 8'h00) begin
                        rd_idx_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d     = ST_HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes arriving while draining cannot be stored; drop and flag.
                overrun_d = i_RX_DV;
                if (i_Data_Ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (drain_last) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // A byte in the terminal cycle wins, so the timeout only fires without one.
        if (timed && !i_RX_DV && (cnt_d == TMO_LAST)) begin
            state_d     = ST_HUNT;
            cnt_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            sum_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_Data_Valid = (state_q == ST_DRAIN);
    assign o_Data_Byte  = o_Data_Valid ? rd_data : 8'h00;
    assign o_Data_Last  = o_Data_Valid && drain_last;
    assign o_Frame_Err  = frame_err_q;
    assign o_Err_Code   = err_code_q;
    assign o_Overrun    = overrun_q;

endmodule
